rom_loader: RTL and testbench
=============================

# rom_loader

Boot-time program loader: the write side of the instruction ROM's `wen`/`w_addr`/`w_data` port, which the SoC otherwise ties off. It accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them to consecutive word addresses from 0. It holds the core in reset until the image is loaded, then releases it. It sits in `riscv_soc` between a byte source (UART receiver or testbench) and `rom`.

## Interface

Parameters:

- `DW`, 32, ROM data width; fixed at 32.
- `AW`, 32, ROM address width.
- `MEM_NUM`, 4096, ROM depth in words; the maximum accepted image length.

Ports (clock and reset first):

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a load.
- `s_valid`  in  1  byte source has a byte.
- `s_data`  in  8  stream byte.
- `s_ready`  out  1  loader accepts a byte; a transfer happens when `s_valid && s_ready`.
- `wen`  out  1  ROM write strobe, one cycle per word.
- `w_addr`  out  AW  ROM byte address, word-aligned (word index × 4).
- `w_data`  out  DW  ROM write word.
- `busy`  out  1  a load is in progress.
- `done`  out  1  the last load completed successfully.
- `err`  out  1  the last load was rejected.
- `core_rstn`  out  1  active-low reset to the core; 0 holds the core in reset.

## Operation

- Frame format:
  - 4 header bytes: word count `LEN`, little-endian.
  - `LEN`×4 payload bytes.
  - With `ROM_LOADER_CSUM_EN` only: 1 trailing checksum byte.
- FSM states: IDLE, LEN, DATA, CSUM, DONE, ERR.
- IDLE:
  - `s_ready`=0.
  - `start` → LEN; clears `done`/`err`; drives `core_rstn`=0; clears the counters and checksum.
- LEN:
  - `s_ready`=1; 4 bytes form `LEN`, the first byte in bits [7:0].
  - `LEN`=0 → CSUM if the macro is defined, else DONE.
  - `LEN` > `MEM_NUM` → ERR.
  - Otherwise → DATA.
- DATA:
  - `s_ready`=1; byte k of each word lands in `w_data[8k+7:8k]`.
  - On acceptance of the 4th byte, the next cycle has `wen`=1, `w_addr`=word_idx×4, and the assembled word on `w_data`; then word_idx increments.
  - After word `LEN`-1 is accepted → CSUM if the macro is defined, else DONE.
- CSUM: described under Configuration.
- DONE: `done`=1, `core_rstn`=1, `busy`=0, `s_ready`=0. Stays in DONE until `start`.
- ERR: `err`=1, `core_rstn`=0, `s_ready`=0, no further writes. Stays in ERR until `start`.
- `busy`=1 exactly in LEN, DATA and CSUM.
- `start` while busy is ignored. `start` in DONE or ERR restarts the load and re-asserts `core_rstn`=0.
- Counters:
  - Byte-in-word counter: 2 bits, wraps 3→0.
  - Word index: `$clog2(MEM_NUM)+1` bits, never wraps (`LEN` ≤ `MEM_NUM`).
  - `w_addr` is zero-extended to `AW`.

## Timing

- Reset values:
  - All state: IDLE.
  - `s_ready`, `wen`, `busy`, `done`, `err`, `core_rstn` = 0.
  - `w_addr`, `w_data` = 0.
  - The core stays in reset from power-up until the first successful load.
- `s_ready` is registered: it rises the cycle after `start`. It stays high through LEN, DATA and CSUM, including the cycle `wen` is high, so back-to-back bytes sustain 1 byte/cycle.
- `wen` is registered and lasts 1 cycle. `w_addr`/`w_data` are valid whenever `wen`=1 and hold their values otherwise.
- Without the macro, the FSM enters DONE at the edge after the final `wen` cycle: `done`/`core_rstn` go to 1 two cycles after the last payload byte is accepted. The final ROM write therefore precedes the core's release.
- `rst` mid-load aborts immediately:
  - Outputs return to their reset values; no partial `wen` follows.
  - ROM contents already written are not cleared.

## Configuration

- `ROM_LOADER_CSUM_EN` defined:
  - An 8-bit running sum (mod 256) of the payload bytes only.
  - CSUM state: `s_ready`=1; accepts one byte.
  - If the byte equals the sum → DONE, else → ERR.
  - On a mismatch the words are already written but the core stays in reset.
- Not defined:
  - The CSUM state and the summing logic are absent.
  - A frame ends with its last payload byte; no trailing byte is consumed.

## Structure

- Package `rom_loader_pkg`:
  - FSM state encoding.
  - `HDR_BYTES`=4, `BYTES_PER_WORD`=4.
- Sub-module `rom_loader_asm`: byte-to-word assembler.
  - Contains the byte counter and shift/merge logic.
  - Outputs a one-cycle `word_valid` with the word.
  - The top owns the FSM, word index, checksum, and the `wen`/`w_addr` registers.

## Test plan

- `LEN`=2, payload 13 00 00 00 / 93 00 10 00, no stalls → writes 0x00000013@0x0 then 0x00100093@0x4. `done`=1 and `core_rstn`=1 two cycles after the last byte.
- The same frame with `s_valid` toggled every other cycle → identical writes and contents; `wen` fires only after each 4th accepted byte.
- Header `LEN`=0x1001 with `MEM_NUM`=4096 → ERR; `err`=1, zero `wen` pulses, `core_rstn` stays 0. A following `start` plus a valid frame → `done`=1.
- `rst` pulsed after the 6th payload byte → one write only (word 0), all outputs at reset values. A fresh `start` reloads correctly from address 0.
- `ROM_LOADER_CSUM_EN`, `LEN`=1, payload 01 02 03 04, checksum 0x0A → `done`=1. The same frame with checksum 0x0B → `err`=1, word written, `core_rstn`=0.
- `start` pulsed while in DATA → ignored; the word sequence and addresses are unchanged.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// Shared definitions for the boot-time ROM loader.
// The optional trailing checksum byte is enabled with ROM_LOADER_CSUM_EN.
package rom_loader_pkg;

    // Loader FSM encoding. ST_CSUM is reachable only when the checksum is enabled.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // The header is one little-endian word, so it goes through the same assembler.
    localparam int HDR_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;

    // A load is in progress while the FSM is collecting header, payload or checksum.
    function automatic logic is_busy(input state_t s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/rom_loader_asm.sv
// Byte-to-word assembler: collects four accepted bytes, lowest byte first.
// word_valid is a one-cycle pulse in the cycle the fourth byte is accepted;
// word then carries the three stored bytes merged with the live byte.
module rom_loader_asm
    import rom_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt;
    logic [23:0] part;

    // Byte position counter (wraps 3->0) and storage for the first three bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= 2'd0;
            part     <= 24'd0;
        end else if (clear) begin
            byte_cnt <= 2'd0;
            part     <= 24'd0;
        end else if (in_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
                2'd0:    part[7:0]   <= in_data;
                2'd1:    part[15:8]  <= in_data;
                2'd2:    part[23:16] <= in_data;
                default: ;
            endcase
        end
    end

    // The fourth byte completes the word without waiting for a register stage.
    assign word_valid = in_valid && !clear && (byte_cnt == 2'(BYTES_PER_WORD - 1));
    assign word       = {in_data, part};

endmodule

// File: rtl/rom_loader.sv
// Boot-time program loader: consumes a framed byte stream
// (4-byte LEN header, LEN*4 payload bytes, optional checksum byte) and
// writes little-endian words to ROM from address 0. The core is held in
// reset until a load completes successfully.
// Optional feature macro: ROM_LOADER_CSUM_EN (trailing 8-bit payload sum).
//
// Handshake: a byte moves when s_valid && s_ready on a rising edge; the
// source may hold s_valid high and change s_data only after a transfer.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int MEM_NUM = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic          wen,
    output logic [AW-1:0] w_addr,
    output logic [DW-1:0] w_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          core_rstn
);

    localparam int IW = $clog2(MEM_NUM) + 1;

    state_t        state;
    state_t        state_next;
    logic          ready_next;
    logic          accept;
    logic          start_ok;
    logic          word_valid;
    logic [31:0]   word;
    logic [IW-1:0] word_idx;
    logic [IW-1:0] len_q;
    logic          last_word;
`ifdef ROM_LOADER_CSUM_EN
    logic [7:0]    sum;
`endif

    assign accept    = s_valid && s_ready;
    // start is honoured only when no load is running.
    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    // True while the word being completed is the final one of the image.
    assign last_word = ((word_idx + IW'(1)) == len_q);

    rom_loader_asm u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .in_valid   (accept),
        .in_data    (s_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Next-state and next-ready decode.
    always_comb begin
        state_next = state;
        ready_next = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_ok) state_next = ST_LEN;
            end
            ST_LEN: begin
                if (word_valid) begin
                    if (word == 32'd0) begin
`ifdef ROM_LOADER_CSUM_EN
                        state_next = ST_CSUM;
`else
                        state_next = ST_DONE;
`endif
                    end else if (word > 32'(MEM_NUM)) begin
                        state_next = ST_ERR;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
`ifdef ROM_LOADER_CSUM_EN
                // The checksum byte may already arrive during the final wen cycle.
                if (word_valid && last_word) state_next = ST_CSUM;
`else
                // Leave only after the final write strobe, so the ROM is written before release.
                if (wen && (word_idx == len_q)) state_next = ST_DONE;
`endif
            end
`ifdef ROM_LOADER_CSUM_EN
            ST_CSUM: begin
                if (accept) state_next = (s_data == sum) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_next = ST_IDLE;
        endcase

        ready_next = is_busy(state_next);
`ifndef ROM_LOADER_CSUM_EN
        // No byte may follow the last payload byte while the final write drains.
        if ((state == ST_DATA) && word_valid && last_word) ready_next = 1'b0;
`endif
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            core_rstn <= 1'b0;
        end else begin
            state     <= state_next;
            s_ready   <= ready_next;
            busy      <= is_busy(state_next);
            done      <= (state_next == ST_DONE);
            err       <= (state_next == ST_ERR);
            core_rstn <= (state_next == ST_DONE);
        end
    end

    // Word index, image length and the ROM write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen      <= 1'b0;
            w_addr   <= '0;
            w_data   <= '0;
            word_idx <= '0;
            len_q    <= '0;
        end else begin
            wen <= 1'b0;
            if (start_ok) begin
                word_idx <= '0;
                len_q    <= '0;
            end else if ((state == ST_LEN) && word_valid && (word <= 32'(MEM_NUM))) begin
                len_q <= word[IW-1:0];
            end else if ((state == ST_DATA) && word_valid) begin
                wen      <= 1'b1;
                w_addr   <= AW'({word_idx, 2'b00});
                w_data   <= DW'(word);
                word_idx <= word_idx + IW'(1);
            end
        end
    end

`ifdef ROM_LOADER_CSUM_EN
    // Running mod-256 sum of payload bytes only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= 8'd0;
        end else if (start_ok) begin
            sum <= 8'd0;
        end else if ((state == ST_DATA) && accept) begin
            sum <= sum + s_data;
        end
    end
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Testbench for rom_loader: directed frames, scoreboard of expected ROM writes.
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_ready;
    logic        wen;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        core_rstn;

    int checks = 0;
    int errors = 0;
    int wen_cnt = 0;
    int wen_base;
    logic [63:0] exp_q[$];
    logic [7:0]  tx_q[$];
    logic [63:0] mon_e;

    rom_loader #(.DW(32), .AW(32), .MEM_NUM(4096)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .wen       (wen),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .core_rstn (core_rstn)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is popped against the expected queue.
    always @(negedge clk) begin
        if (wen === 1'b1) begin
            wen_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write", w_addr, w_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({w_addr, w_data} !== mon_e) begin
                    errors++;
                    $display("FAIL rom_write: got addr 0x%08h data 0x%08h expected addr 0x%08h data 0x%08h",
                             w_addr, w_data, mon_e[63:32], mon_e[31:0]);
                end
            end
        end
    end

    // Driver: present one byte and return at the negedge after it is accepted.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (s_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL s_ready_timeout: got s_ready=%0b expected 1 within 50 cycles", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_queue(input bit stall);
        while (tx_q.size() > 0) begin
            send_byte(tx_q.pop_front());
            if (stall) @(negedge clk);
        end
    endtask

    task automatic push_hdr(input logic [31:0] len);
        tx_q.push_back(len[7:0]);
        tx_q.push_back(len[15:8]);
        tx_q.push_back(len[23:16]);
        tx_q.push_back(len[31:24]);
    endtask

    // Frame A: LEN=2, words 0x00000013 and 0x00100093; payload sum 0xB6.
    task automatic push_frame_a();
        push_hdr(32'd2);
        tx_q.push_back(8'h13); tx_q.push_back(8'h00); tx_q.push_back(8'h00); tx_q.push_back(8'h00);
        tx_q.push_back(8'h93); tx_q.push_back(8'h00); tx_q.push_back(8'h10); tx_q.push_back(8'h00);
`ifdef ROM_LOADER_CSUM_EN
        tx_q.push_back(8'hB6);
`endif
        exp_q.push_back({32'h0000_0000, 32'h0000_0013});
        exp_q.push_back({32'h0000_0004, 32'h0010_0093});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int t;
        t = 0;
        while (!(done === 1'b1 || err === 1'b1) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got done=%0b err=%0b expected one of them within 100 cycles", name, done, err);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"},   {31'd0, s_ready},   32'd0);
        chk({tag, "_wen"},       {31'd0, wen},       32'd0);
        chk({tag, "_busy"},      {31'd0, busy},      32'd0);
        chk({tag, "_done"},      {31'd0, done},      32'd0);
        chk({tag, "_err"},       {31'd0, err},       32'd0);
        chk({tag, "_core_rstn"}, {31'd0, core_rstn}, 32'd0);
        chk({tag, "_w_addr"},    w_addr,             32'd0);
        chk({tag, "_w_data"},    w_data,             32'd0);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");

        // Test 1: frame A back-to-back
        pulse_start();
        chk("t1_s_ready_after_start", {31'd0, s_ready}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_core_rstn_held", {31'd0, core_rstn}, 32'd0);
        push_frame_a();
        send_queue(1'b0);
`ifdef ROM_LOADER_CSUM_EN
        chk("t1_done", {31'd0, done}, 32'd1);
`else
        chk("t1_wen_after_last", {31'd0, wen}, 32'd1);
        chk("t1_done_not_yet", {31'd0, done}, 32'd0);
        chk("t1_s_ready_low", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_core_rstn", {31'd0, core_rstn}, 32'd1);
        chk("t1_busy_low", {31'd0, busy}, 32'd0);
`endif
        repeat (2) @(negedge clk);
        chk("t1_queue_empty", exp_q.size(), 32'd0);
        chk("t1_w_addr_hold", w_addr, 32'h4);
        chk("t1_w_data_hold", w_data, 32'h0010_0093);

        // Test 2: same frame, s_valid toggled every other cycle
        wen_base = wen_cnt;
        pulse_start();
        chk("t2_done_cleared", {31'd0, done}, 32'd0);
        chk("t2_core_rstn_low", {31'd0, core_rstn}, 32'd0);
        push_frame_a();
        send_queue(1'b1);
        wait_end("t2");
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_wen_count", wen_cnt - wen_base, 32'd2);
        chk("t2_queue_empty", exp_q.size(), 32'd0);

        // Test 3: oversize LEN=0x1001 rejected, then recovery
        wen_base = wen_cnt;
        pulse_start();
        push_hdr(32'h0000_1001);
        send_queue(1'b0);
        chk("t3_err", {31'd0, err}, 32'd1);
        chk("t3_core_rstn", {31'd0, core_rstn}, 32'd0);
        chk("t3_s_ready", {31'd0, s_ready}, 32'd0);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        chk("t3_no_writes", wen_cnt - wen_base, 32'd0);
        chk("t3_err_held", {31'd0, err}, 32'd1);
        pulse_start();
        chk("t3_err_cleared", {31'd0, err}, 32'd0);
        push_frame_a();
        send_queue(1'b0);
        wait_end("t3");
        chk("t3_done_after_retry", {31'd0, done}, 32'd1);
        chk("t3_queue_empty", exp_q.size(), 32'd0);

        // Test 4: reset after the 6th payload byte
        wen_base = wen_cnt;
        pulse_start();
        push_hdr(32'd2);
        tx_q.push_back(8'h13); tx_q.push_back(8'h00); tx_q.push_back(8'h00); tx_q.push_back(8'h00);
        tx_q.push_back(8'h93); tx_q.push_back(8'h00);
        exp_q.push_back({32'h0000_0000, 32'h0000_0013});
        send_queue(1'b0);
        rst = 1'b1;
        #1;
        check_reset_outputs("t4_abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_one_write", wen_cnt - wen_base, 32'd1);
        chk("t4_queue_empty", exp_q.size(), 32'd0);
        chk("t4_core_rstn_low", {31'd0, core_rstn}, 32'd0);
        pulse_start();
        push_frame_a();
        send_queue(1'b0);
        wait_end("t4");
        chk("t4_reload_done", {31'd0, done}, 32'd1);
        chk("t4_reload_queue_empty", exp_q.size(), 32'd0);

        // Test 5: start pulsed mid-DATA is ignored
        wen_base = wen_cnt;
        pulse_start();
        push_frame_a();
        repeat (6) send_byte(tx_q.pop_front());
        start = 1'b1;
        send_byte(tx_q.pop_front());
        start = 1'b0;
        chk("t5_busy_kept", {31'd0, busy}, 32'd1);
        send_queue(1'b0);
        wait_end("t5");
        chk("t5_done", {31'd0, done}, 32'd1);
        chk("t5_wen_count", wen_cnt - wen_base, 32'd2);
        chk("t5_queue_empty", exp_q.size(), 32'd0);

`ifdef ROM_LOADER_CSUM_EN
        // Test 6: checksum accepted (0x01+0x02+0x03+0x04 = 0x0A)
        pulse_start();
        push_hdr(32'd1);
        tx_q.push_back(8'h01); tx_q.push_back(8'h02); tx_q.push_back(8'h03); tx_q.push_back(8'h04);
        tx_q.push_back(8'h0A);
        exp_q.push_back({32'h0000_0000, 32'h0403_0201});
        send_queue(1'b0);
        wait_end("t6");
        chk("t6_done", {31'd0, done}, 32'd1);
        chk("t6_core_rstn", {31'd0, core_rstn}, 32'd1);

        // Test 7: checksum rejected, word still written
        pulse_start();
        push_hdr(32'd1);
        tx_q.push_back(8'h01); tx_q.push_back(8'h02); tx_q.push_back(8'h03); tx_q.push_back(8'h04);
        tx_q.push_back(8'h0B);
        exp_q.push_back({32'h0000_0000, 32'h0403_0201});
        send_queue(1'b0);
        wait_end("t7");
        chk("t7_err", {31'd0, err}, 32'd1);
        chk("t7_core_rstn", {31'd0, core_rstn}, 32'd0);
        chk("t7_queue_empty", exp_q.size(), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
